// File: rtl/press_ack_counter_pkg.sv
// Shared state and operation codes for the press/ack counter consumer.
package press_ack_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACK     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } op_t;

endpackage

// File: rtl/press_ack_counter_arbiter.sv
// Fixed-priority selection among the three pending press flags (load > inc > dec).
module press_priority_arbiter
   import press_ack_counter_pkg::*;
(
   input  logic load_req,
   input  logic inc_req,
   input  logic dec_req,
   output op_t  op
);

   always_comb begin
      op = OP_NONE;
      if (load_req)     op = OP_LOAD;
      else if (inc_req) op = OP_INC;
      else if (dec_req) op = OP_DEC;
   end

endmodule

// File: rtl/press_ack_counter.sv
// Services one press per pass: grant, one-cycle ack with counter update, then wait
// for the granted detector to drop its flag before accepting the next press.
module press_ack_counter
   import press_ack_counter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int RESET_VALUE = 0,
   parameter bit WRAP        = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             loadPressed,
   input  logic             incPressed,
   input  logic             decPressed,
   input  logic [WIDTH-1:0] loadValue,
   output logic             loadAck,
   output logic             incAck,
   output logic             decAck,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             limitHit
);

   localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   op_t              grant_q, grant_d;
   op_t              req_op;
   logic [WIDTH-1:0] count_q, count_d;
   logic             limit_q, limit_d;
   logic             granted_pressed;

   press_priority_arbiter u_arb (
      .load_req (loadPressed),
      .inc_req  (incPressed),
      .dec_req  (decPressed),
      .op       (req_op)
   );

   always_comb begin
      case (grant_q)
         OP_LOAD: granted_pressed = loadPressed;
         OP_INC:  granted_pressed = incPressed;
         OP_DEC:  granted_pressed = decPressed;
         default: granted_pressed = 1'b0;
      endcase
   end

   // The counter only moves on the edge that ends ACK; limit flags a wrap or clamp there.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      count_d = count_q;
      limit_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_op != OP_NONE) begin
               grant_d = req_op;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_RELEASE;
            case (grant_q)
               OP_LOAD: count_d = loadValue;
               OP_INC: begin
                  if (count_q == CNT_MAX) begin
                     limit_d = 1'b1;
                     count_d = WRAP ? '0 : CNT_MAX;
                  end else begin
                     count_d = count_q + CNT_ONE;
                  end
               end
               OP_DEC: begin
                  if (count_q == '0) begin
                     limit_d = 1'b1;
                     count_d = WRAP ? CNT_MAX : '0;
                  end else begin
                     count_d = count_q - CNT_ONE;
                  end
               end
               default: count_d = count_q;
            endcase
         end
         ST_RELEASE: begin
            if (!granted_pressed) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= OP_NONE;
         count_q <= CNT_RST;
         limit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         count_q <= count_d;
         limit_q <= limit_d;
      end
   end

   assign loadAck  = (state_q == ST_ACK) && (grant_q == OP_LOAD);
   assign incAck   = (state_q == ST_ACK) && (grant_q == OP_INC);
   assign decAck   = (state_q == ST_ACK) && (grant_q == OP_DEC);
   assign busy     = (state_q != ST_IDLE);
   assign count    = count_q;
   assign limitHit = limit_q;

endmodule

// File: tb/tb_press_ack_counter.sv
// Directed bench: a wrapping instance (reset value 5) and a saturating instance
// (reset value 0) share the same press inputs.
module tb_press_ack_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       loadPressed, incPressed, decPressed;
   logic [7:0] loadValue;
   logic       loadAck, incAck, decAck, busy, limitHit;
   logic [7:0] count;
   logic       s_loadAck, s_incAck, s_decAck, s_busy, s_limitHit;
   logic [7:0] s_count;
   logic [2:0] ack_v, s_ack_v;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   assign ack_v   = {loadAck, incAck, decAck};
   assign s_ack_v = {s_loadAck, s_incAck, s_decAck};

   press_ack_counter #(.WIDTH(8), .RESET_VALUE(5), .WRAP(1'b1)) dut (
      .clock(clock), .reset(reset),
      .loadPressed(loadPressed), .incPressed(incPressed), .decPressed(decPressed),
      .loadValue(loadValue),
      .loadAck(loadAck), .incAck(incAck), .decAck(decAck),
      .count(count), .busy(busy), .limitHit(limitHit)
   );

   press_ack_counter #(.WIDTH(8), .RESET_VALUE(0), .WRAP(1'b0)) dut_sat (
      .clock(clock), .reset(reset),
      .loadPressed(loadPressed), .incPressed(incPressed), .decPressed(decPressed),
      .loadValue(loadValue),
      .loadAck(s_loadAck), .incAck(s_incAck), .decAck(s_decAck),
      .count(s_count), .busy(s_busy), .limitHit(s_limitHit)
   );

   typedef struct {
      logic       rst, ld, in, dc;
      logic [7:0] lv;
      logic [7:0] cnt;
      logic [2:0] ack;
      logic       bsy, lim;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, l, i, d, input logic [7:0] lv, cnt,
                      input logic [2:0] ack, input logic b, lm);
      vq.push_back('{r, l, i, d, lv, cnt, ack, b, lm});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Press one source, let the modelled detector drop its flag one cycle after the ack.
   task automatic service(input logic [2:0] m, input logic [7:0] lv,
                          output logic lm, output logic ls);
      int n;
      {loadPressed, incPressed, decPressed} = m;
      loadValue = lv;
      n = 0;
      while (((ack_v & m) == 3'b000) && n < 8) begin
         tick();
         n++;
      end
      check("ack_seen", 32'((ack_v & m) != 3'b000), 32'd1);
      tick();
      lm = limitHit;
      ls = s_limitHit;
      tick();
      {loadPressed, incPressed, decPressed} = 3'b000;
      n = 0;
      while (busy && n < 8) begin
         tick();
         n++;
      end
      check("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      logic lm, ls;
      reset = 1'b1;
      {loadPressed, incPressed, decPressed} = 3'b000;
      loadValue = 8'h00;

      // reset, single inc service, then simultaneous load/inc/dec
      add(1,0,0,0, 8'h00, 8'h05, 3'b000, 0, 0);
      add(1,0,1,0, 8'h00, 8'h05, 3'b000, 0, 0);
      add(0,0,1,0, 8'h00, 8'h05, 3'b010, 1, 0);
      add(0,0,1,0, 8'h00, 8'h06, 3'b000, 1, 0);
      add(0,0,1,0, 8'h00, 8'h06, 3'b000, 1, 0);
      add(0,0,0,0, 8'h00, 8'h06, 3'b000, 0, 0);
      add(0,1,1,1, 8'h10, 8'h06, 3'b100, 1, 0);
      add(0,1,1,1, 8'h10, 8'h10, 3'b000, 1, 0);
      add(0,1,1,1, 8'h10, 8'h10, 3'b000, 1, 0);
      add(0,0,1,1, 8'h10, 8'h10, 3'b000, 0, 0);
      add(0,0,1,1, 8'h10, 8'h10, 3'b010, 1, 0);
      add(0,0,1,1, 8'h10, 8'h11, 3'b000, 1, 0);
      add(0,0,1,1, 8'h10, 8'h11, 3'b000, 1, 0);
      add(0,0,0,1, 8'h10, 8'h11, 3'b000, 0, 0);
      add(0,0,0,1, 8'h10, 8'h11, 3'b001, 1, 0);
      add(0,0,0,1, 8'h10, 8'h10, 3'b000, 1, 0);
      add(0,0,0,1, 8'h10, 8'h10, 3'b000, 1, 0);
      add(0,0,0,0, 8'h10, 8'h10, 3'b000, 0, 0);

      foreach (vq[k]) begin
         reset = vq[k].rst;
         {loadPressed, incPressed, decPressed} = {vq[k].ld, vq[k].in, vq[k].dc};
         loadValue = vq[k].lv;
         tick();
         check($sformatf("v%0d_count", k), 32'(count), 32'(vq[k].cnt));
         check($sformatf("v%0d_acks", k), 32'(ack_v), 32'(vq[k].ack));
         check($sformatf("v%0d_busy", k), 32'(busy), 32'(vq[k].bsy));
         check($sformatf("v%0d_limit", k), 32'(limitHit), 32'(vq[k].lim));
      end
      check("sat_count_tbl", 32'(s_count), 32'h10);

      // wrap and saturate boundaries
      service(3'b100, 8'hFF, lm, ls);
      check("load_ff_count", 32'(count), 32'hFF);
      check("load_ff_lim", 32'({lm, ls}), 32'd0);
      service(3'b010, 8'h00, lm, ls);
      check("inc_wrap_count", 32'(count), 32'h00);
      check("inc_wrap_lim", 32'(lm), 32'd1);
      check("inc_sat_count", 32'(s_count), 32'hFF);
      check("inc_sat_lim", 32'(ls), 32'd1);
      service(3'b001, 8'h00, lm, ls);
      check("dec_wrap_count", 32'(count), 32'hFF);
      check("dec_wrap_lim", 32'(lm), 32'd1);
      check("dec_sat_count", 32'(s_count), 32'hFE);
      check("dec_sat_nolim", 32'(ls), 32'd0);
      service(3'b100, 8'h00, lm, ls);
      service(3'b001, 8'h00, lm, ls);
      check("dec0_wrap_count", 32'(count), 32'hFF);
      check("dec0_sat_count", 32'(s_count), 32'h00);
      check("dec0_lims", 32'({lm, ls}), 32'b11);

      // flag held long after the ack: a single increment only
      incPressed = 1'b1;
      tick();
      check("hold_ack", 32'(ack_v), 32'b010);
      tick();
      for (int c = 0; c < 6; c++) begin
         tick();
         check("hold_busy", 32'(busy), 32'd1);
         check("hold_acks", 32'(ack_v), 32'd0);
         check("hold_count", 32'(count), 32'h00);
      end
      incPressed = 1'b0;
      tick();
      check("hold_idle", 32'(busy), 32'd0);
      check("hold_final", 32'({count, s_count}), 32'h0001);

      // reset arriving during ACK suppresses the update
      incPressed = 1'b1;
      tick();
      check("rst_pre_ack", 32'(ack_v), 32'b010);
      reset = 1'b1;
      tick();
      check("rst_count", 32'(count), 32'h05);
      check("rst_sat_count", 32'(s_count), 32'h00);
      check("rst_acks", 32'({ack_v, s_ack_v}), 32'd0);
      check("rst_busy", 32'({busy, s_busy}), 32'd0);
      reset = 1'b0;
      incPressed = 1'b0;
      tick();
      tick();
      check("rst_after", 32'({busy, count}), 32'h005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
